// File: rtl/led_fabric_pkg.sv
// Shared definitions for the fabric LED path: fade FSM states and default rates.
package led_fabric_pkg;

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_RISING  = 2'd1,
      ST_ON      = 2'd2,
      ST_FALLING = 2'd3
   } fade_state_e;

   localparam int CLK_HZ   = 50_000_000;
   localparam int PWM_BITS = 8;
   localparam int FADE_DIV = 49_000;

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM with a period-aligned shadow duty, so duty updates never glitch mid-period.
module led_pwm_gen #(
   parameter int PWM_BITS = 8
) (
   input  logic                clk_50mhz,
   input  logic                rst,
   input  logic [PWM_BITS-1:0] duty_i,
   output logic                pwm_o
);

   localparam logic [PWM_BITS-1:0] MAX = '1;

   logic [PWM_BITS-1:0] cnt_q, cnt_d;
   logic [PWM_BITS-1:0] shadow_q, shadow_d;
   logic                pwm_q, pwm_d;

   always_comb begin
      cnt_d    = cnt_q + 1'b1;
      shadow_d = (cnt_q == MAX) ? duty_i : shadow_q;
      // Full scale forces constant high; otherwise MAX would leave one low clock per period.
      pwm_d    = (shadow_q == MAX) || (cnt_q < shadow_q);
   end

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         cnt_q    <= '0;
         shadow_q <= '0;
         pwm_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         pwm_q    <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/led_fade_driver.sv
// LED fade driver: ramps PWM duty linearly toward the blinker's requested level.
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_OFF     | duty held at 0, waiting for led_req
// ST_RISING  | duty +1 per step tick until full scale
// ST_ON      | duty held at full scale, waiting for led_req drop
// ST_FALLING | duty -1 per step tick until 0
module led_fade_driver #(
   parameter int PWM_BITS = led_fabric_pkg::PWM_BITS,
   parameter int FADE_DIV = led_fabric_pkg::FADE_DIV
) (
   input  logic                clk_50mhz,
   input  logic                rst,
   input  logic                led_req,
   input  logic                fade_en,
   output logic                led_pwm,
   output logic [PWM_BITS-1:0] duty,
   output logic                busy
);

   import led_fabric_pkg::*;

   localparam logic [PWM_BITS-1:0] MAX   = '1;
   localparam int                  TMR_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
   localparam logic [TMR_W-1:0]    TMR_TC = TMR_W'(FADE_DIV - 1);

   fade_state_e         state_q, state_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic                busy_q, busy_d;

   logic                tick;
   logic [PWM_BITS-1:0] duty_inc, duty_dec;
   logic [PWM_BITS-1:0] target;

   assign tick     = (tmr_q == TMR_TC);
   assign duty_inc = (duty_q == MAX) ? MAX : duty_q + 1'b1;
   assign duty_dec = (duty_q == '0) ? '0 : duty_q - 1'b1;
   assign target   = led_req ? MAX : '0;

   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      case (state_q)
         ST_OFF: begin
            if (led_req) begin
               if (fade_en) begin
                  state_d = ST_RISING;
               end else begin
                  duty_d  = MAX;
                  state_d = ST_ON;
               end
            end
         end
         ST_RISING: begin
            if (!fade_en) begin
               duty_d  = target;
               state_d = led_req ? ST_ON : ST_OFF;
            end else if (!led_req) begin
               state_d = ST_FALLING;
            end else if (tick) begin
               duty_d = duty_inc;
               if (duty_inc == MAX) state_d = ST_ON;
            end
         end
         ST_ON: begin
            if (!led_req) begin
               if (fade_en) begin
                  state_d = ST_FALLING;
               end else begin
                  duty_d  = '0;
                  state_d = ST_OFF;
               end
            end
         end
         ST_FALLING: begin
            if (!fade_en) begin
               duty_d  = target;
               state_d = led_req ? ST_ON : ST_OFF;
            end else if (led_req) begin
               state_d = ST_RISING;
            end else if (tick) begin
               duty_d = duty_dec;
               if (duty_dec == '0) state_d = ST_OFF;
            end
         end
         default: begin
            state_d = ST_OFF;
            duty_d  = '0;
         end
      endcase
   end

   // Any state change, reversals included, restarts the step interval from zero.
   always_comb begin
      tmr_d = '0;
      if (state_d == state_q && (state_q == ST_RISING || state_q == ST_FALLING)) begin
         tmr_d = tick ? '0 : tmr_q + 1'b1;
      end
      busy_d = (state_d == ST_RISING) || (state_d == ST_FALLING);
   end

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         state_q <= ST_OFF;
         duty_q  <= '0;
         tmr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         tmr_q   <= tmr_d;
         busy_q  <= busy_d;
      end
   end

   led_pwm_gen #(
      .PWM_BITS (PWM_BITS)
   ) u_pwm (
      .clk_50mhz (clk_50mhz),
      .rst       (rst),
      .duty_i    (duty_q),
      .pwm_o     (led_pwm)
   );

   assign duty = duty_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver with PWM_BITS=4, FADE_DIV=4.
module tb_led_fade_driver;

   localparam int PB  = 4;
   localparam int FD  = 4;
   localparam int MAX = 15;

   logic          clk_50mhz = 1'b0;
   logic          rst;
   logic          led_req;
   logic          fade_en;
   logic          led_pwm;
   logic [PB-1:0] duty;
   logic          busy;

   int total = 0;
   int bad   = 0;

   led_fade_driver #(
      .PWM_BITS (PB),
      .FADE_DIV (FD)
   ) dut (
      .clk_50mhz (clk_50mhz),
      .rst       (rst),
      .led_req   (led_req),
      .fade_en   (fade_en),
      .led_pwm   (led_pwm),
      .duty      (duty),
      .busy      (busy)
   );

   always #5 clk_50mhz = ~clk_50mhz;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk_50mhz);
         @(negedge clk_50mhz);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Counts high samples of led_pwm over n clocks.
   task automatic count_high(input int n, output int hi);
      hi = 0;
      for (int i = 0; i < n; i++) begin
         cyc(1);
         if (led_pwm === 1'b1) hi++;
      end
   endtask

   initial begin
      int hi;
      int rises;
      logic prev;

      rst = 1'b1; led_req = 1'b1; fade_en = 1'b1;
      @(negedge clk_50mhz);

      // Reset held with led_req high
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("rst_pwm", led_pwm, 0);
         chk("rst_duty", duty, 0);
         chk("rst_busy", busy, 0);
      end

      // Full ramp: RISING one clock after release, then one step per FD clocks
      rst = 1'b0;
      cyc(1);
      chk("ramp_busy_start", busy, 1);
      chk("ramp_duty_start", duty, 0);
      for (int k = 1; k <= MAX; k++) begin
         cyc(FD - 1);
         chk("ramp_pre_step", duty, k - 1);
         chk("ramp_busy_mid", busy, 1);
         cyc(1);
         chk("ramp_step", duty, k);
      end
      chk("ramp_busy_end", busy, 0);
      cyc(32);
      count_high(16, hi);
      chk("full_pwm_high", hi, 16);

      // PWM accuracy at duty 5: ramp to 5, then hold by toggling led_req every clock
      led_req = 1'b0; rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(1);
      chk("off_idle_duty", duty, 0);
      led_req = 1'b1;
      cyc(1);
      chk("hold_busy_start", busy, 1);
      cyc(5 * FD);
      chk("hold_duty_reach", duty, 5);
      for (int i = 0; i < 34; i++) begin
         led_req = ~led_req;
         cyc(1);
      end
      hi = 0; rises = 0;
      prev = led_pwm;
      for (int i = 0; i < 32; i++) begin
         led_req = ~led_req;
         cyc(1);
         if (led_pwm === 1'b1) hi++;
         if (prev === 1'b0 && led_pwm === 1'b1) rises++;
         prev = led_pwm;
      end
      chk("pwm5_high", hi, 10);
      chk("pwm5_rises", rises, 2);
      chk("hold_duty", duty, 5);
      chk("hold_busy", busy, 1);

      // Make sure we end in RISING with a fresh timer
      led_req = 1'b0;
      cyc(1);
      led_req = 1'b1;
      cyc(1);
      chk("rev_duty_pre", duty, 5);
      cyc(FD);
      chk("rev_duty6", duty, 6);
      cyc(FD);
      chk("rev_duty7", duty, 7);

      // Reversal at duty 7
      led_req = 1'b0;
      cyc(1);
      chk("rev_busy", busy, 1);
      chk("rev_duty_kept", duty, 7);
      cyc(FD - 1);
      chk("rev_no_early_step", duty, 7);
      cyc(1);
      chk("rev_first_dec", duty, 6);
      cyc(6 * FD - 1);
      chk("fall_pre_off_duty", duty, 1);
      chk("fall_pre_off_busy", busy, 1);
      cyc(1);
      chk("fall_off_duty", duty, 0);
      chk("fall_off_busy", busy, 0);
      cyc(32);
      count_high(16, hi);
      chk("off_pwm_high", hi, 0);

      // Bypass from OFF
      fade_en = 1'b0; led_req = 1'b1;
      cyc(1);
      chk("byp_on_duty", duty, MAX);
      chk("byp_on_busy", busy, 0);
      led_req = 1'b0;
      cyc(1);
      chk("byp_off_duty", duty, 0);
      chk("byp_off_busy", busy, 0);

      // fade_en dropped mid-ramp at duty 9
      fade_en = 1'b1; led_req = 1'b1;
      cyc(1);
      chk("mid_busy", busy, 1);
      cyc(9 * FD);
      chk("mid_duty9", duty, 9);
      fade_en = 1'b0;
      cyc(1);
      chk("mid_jump_duty", duty, MAX);
      chk("mid_jump_busy", busy, 0);

      // Reset mid-ramp at duty 10
      led_req = 1'b0;
      cyc(1);
      chk("pre_rst_off", duty, 0);
      fade_en = 1'b1; led_req = 1'b1;
      cyc(1);
      cyc(10 * FD);
      chk("rr_duty10", duty, 10);
      chk("rr_busy", busy, 1);
      rst = 1'b1;
      cyc(1);
      chk("rr_duty", duty, 0);
      chk("rr_busy_clr", busy, 0);
      chk("rr_pwm", led_pwm, 0);
      rst = 1'b0;
      cyc(1);
      chk("rr_restart_busy", busy, 1);
      chk("rr_restart_duty", duty, 0);
      cyc(FD);
      chk("rr_restart_step", duty, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/led_fade_driver.md
# led_fade_driver

Downstream stage of the fabric LED blinker: takes the blinker's level-type LED request and drives the physical LED pin with a PWM signal. Brightness ramps linearly between off and full instead of switching hard. Runs on the 50 MHz FIC fabric clock and sits between the blink logic and the LED output pad.

## Interface
- `PWM_BITS`, 8: PWM counter and duty width. PWM period is 2^PWM_BITS clocks (256 clocks, about 195 kHz).
- `FADE_DIV`, 49_000: clocks per one-LSB duty step. A full 0↔255 ramp takes 255×49_000 clocks, about 0.25 s.
- `clk_50mhz`, in, 1: 50 MHz fabric clock from FIC. Single clock domain.
- `rst`, in, 1: synchronous reset, active-high.
- `led_req`, in, 1: requested LED state from the blinker (1 = on). Synchronous to `clk_50mhz`.
- `fade_en`, in, 1: 1 = ramp the duty; 0 = duty jumps straight to target.
- `led_pwm`, out, 1: registered PWM drive to the LED pad.
- `duty`, out, PWM_BITS: current working duty value.
- `busy`, out, 1: high while a ramp is in progress (state RISING or FALLING).

## Operation
- Target duty is MAX = 2^PWM_BITS−1 when `led_req`=1, otherwise 0.
- FSM states and transitions:
  - OFF: duty=0. If `led_req`=1: go to RISING when `fade_en`=1; otherwise set duty=MAX and go to ON.
  - RISING: on each step tick, duty += 1. Reaching MAX moves to ON. If `led_req` drops, go to FALLING; duty is kept.
  - ON: duty=MAX. Mirrors OFF: `led_req`=0 goes to FALLING, or sets duty=0 and goes to OFF when `fade_en`=0.
  - FALLING: on each step tick, duty −= 1. Reaching 0 moves to OFF. If `led_req` rises, go to RISING.
- `fade_en`=0 while in RISING or FALLING: duty jumps to target on the next cycle, and the FSM goes to ON or OFF.
- Step timer:
  - Counts 0..FADE_DIV−1 and only while in RISING or FALLING. Terminal count is the step tick.
  - Clears on any state change, including a mid-ramp reversal, so the first step after a reversal comes FADE_DIV clocks later.
- Duty saturates: it never wraps past 0 or MAX.
- PWM:
  - Free-running counter `pwm_cnt`, 0..MAX, wraps to 0.
  - Shadow duty loads from `duty` only when `pwm_cnt`=MAX, so duty changes never produce a glitch mid-period.
  - `led_pwm` = (shadow == MAX) ? 1 : (pwm_cnt < shadow).
  - Result: shadow 0 means constant low; shadow MAX means constant high.

## Timing
- Reset values, when `rst`=1 at a clock edge:
  - state=OFF, duty=0, `led_pwm`=0, `busy`=0.
  - `pwm_cnt`=0, shadow=0, step timer=0.
- Reset mid-ramp aborts the ramp immediately. It takes priority over every other input.
- `led_req` edge to state change: 1 clock. `busy` is registered and rises in that same cycle.
- Duty step to `led_pwm` effect: the next PWM period boundary, at most 2^PWM_BITS clocks.
- `led_pwm` is registered, with 1 clock of latency after the compare.
- Full ramp length is MAX×FADE_DIV clocks, measured from the state change to entry into ON/OFF.
- `led_req` toggling every clock is legal. The FSM simply ping-pongs between RISING and FALLING, duty holds, and the timer keeps clearing.

## Structure
- Shared package `led_fabric_pkg` holds:
  - the FSM state enum (OFF, RISING, ON, FALLING);
  - the default constants CLK_HZ=50_000_000, PWM_BITS=8 and FADE_DIV=49_000.
- Natural sub-module: `led_pwm_gen`, containing `pwm_cnt`, the shadow register and the compare/output register, parameterised by PWM_BITS.
- The fade FSM, step timer and duty register live in `led_fade_driver`.

## Test plan
Bench parameters: PWM_BITS=4, FADE_DIV=4.
- Reset: hold `rst` 3 clocks with `led_req`=1 → `led_pwm`=0, `duty`=0, `busy`=0 throughout. RISING entered 1 clock after release.
- Full ramp, `fade_en`=1, `led_req` 0→1 → `duty` goes 1,2,…,15, one step every 4 clocks. ON reached 60 clocks after the state change. `busy` falls on the same edge. `led_pwm` is constant 1 after the next period boundary.
- PWM accuracy: force duty=5 (ramp and hold) → `led_pwm` high exactly 5 of every 16 clocks, changing only at `pwm_cnt` wrap.
- Reversal: drop `led_req` when `duty`=7 → FALLING; next decrement to 6 occurs exactly 4 clocks later; OFF is reached with `duty`=0 and `led_pwm` constant 0.
- Bypass: `fade_en`=0 → `led_req` 0→1 gives `duty`=15 next clock, `busy` never high. Deasserting `fade_en` mid-ramp at `duty`=9 gives `duty`=15 next clock.
- Reset mid-ramp at `duty`=10 → all outputs at reset values on the next clock; ramp restarts from 0 after release.
